ex_alu_unit: RTL
================

Name: ex_alu_unit

Overview:
- Parametrised next-generation execute-stage ALU. Integrates operand selection (PC/register/immediate), the RV32I ALU op set and RV32M multiply/divide in one block.
- Single-cycle ops produce a registered result. DIV/DIVU/REM/REMU run on an iterative restoring divider.
- Sits between the ID/EX pipeline register and the EX/MEM register. Uses a valid/ready handshake so hazard control can stall on multi-cycle ops.

Parameters:
- XLEN, 32, datapath width (>=8, power of two)
- TAG_W, 5, width of sideband tag carried with each op (e.g. rd index)
- PC_STEP, 4, constant used as operand B in link mode

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  kill in-flight/held op (branch mispredict)
- in_valid  in  1  operation offered
- in_ready  out  1  unit accepts operation this cycle
- pc_ex  in  XLEN  PC of the EX instruction
- reg_1_in  in  XLEN  rs1 value
- reg_2_in  in  XLEN  rs2 value
- imm_data_in  in  XLEN  sign-extended immediate
- alu_mode_select  in  2  operand select: 0 {rs1,rs2}, 1 {rs1,imm}, 2 {pc,imm}, 3 {pc,PC_STEP}
- alu_op  in  5  operation code (see Behaviour)
- tag_in  in  TAG_W  sideband tag
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- alu_result_out  out  XLEN  result
- alu_zero_out  out  1  result == 0
- tag_out  out  TAG_W  tag of the result
- busy  out  1  divider iterating

Behaviour:
- Reset (synchronous, rst=1 at clk edge): state=IDLE, out_valid=0, alu_result_out=0, alu_zero_out=1, tag_out=0, busy=0. in_ready is 0 while rst is high.
- Operands A/B are muxed per alu_mode_select at acceptance and latched into the divider if needed.
- Opcodes:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB (LUI)
  - 16 MUL, 17 MULH, 18 MULHSU, 19 MULHU, 20 DIV, 21 DIVU, 22 REM, 23 REMU
  - Any other code yields result 0.
- Shifts use B[log2(XLEN)-1:0]. SLT/SLTU return 0/1 zero-extended. Arithmetic wraps modulo 2^XLEN.
- MUL returns the low XLEN bits. MULH/MULHSU/MULHU return the high XLEN bits of the 2*XLEN product with signed*signed, signed*unsigned and unsigned*unsigned operands respectively.
- Handshake: an op is accepted when in_valid && in_ready. in_ready = (state==IDLE) && (!out_valid || out_ready) && !rst.
- Output holds: while out_valid && !out_ready, alu_result_out, alu_zero_out and tag_out are stable.
- State machine:
  - IDLE: an accepted single-cycle op (codes 0-19, others) loads the output register at that edge, so out_valid=1 the next cycle (latency 1). Back-to-back accepts are allowed when the output is consumed in the same cycle (throughput 1/cycle).
  - IDLE -> DIV_RUN on acceptance of codes 20-23. busy=1; the divider runs XLEN iterations on magnitudes.
  - DIV_RUN -> IDLE after the XLEN-th iteration. The sign-corrected result is loaded into the output register, so out_valid rises exactly XLEN+1 cycles after acceptance. in_ready=0 throughout DIV_RUN.
- Divide special cases (full latency kept):
  - B=0: DIV/DIVU = all ones; REM/REMU = A.
  - Signed overflow (A=-2^(XLEN-1), B=-1): DIV = A, REM = 0.
  - Signs: quotient is negative iff the operand signs differ; remainder takes the sign of the dividend.
- alu_zero_out = (alu_result_out == 0), registered together with the result.
- flush (priority below rst, above everything else): state -> IDLE, out_valid -> 0, busy -> 0 at the next edge. An op presented in the same cycle as flush is not accepted (in_ready is forced low while flush=1).
- rst or flush mid-division discards the partial result; no stale out_valid appears afterwards.
- A simultaneous output consume and new accept in IDLE: the output register is overwritten with the new result, and out_valid stays 1.

Test Plan:
- Reset: hold rst 2 cycles with in_valid=1 -> out_valid=0, alu_result_out=0, alu_zero_out=1, in_ready=0. After release, in_ready=1.
- Modes/ALU: mode 0, SUB, rs1=5, rs2=5 -> next cycle out_valid=1, result 0, zero=1. Mode 2, ADD, pc=0x100, imm=0x20 -> 0x120. Mode 3, ADD, pc=0x100 -> 0x104. SRA, rs1=0x80000000, rs2=0x21 -> 0xC0000000. Back-to-back ops with out_ready=1 -> one result per cycle in order, tags preserved.
- Multiply: MULH, 0xFFFFFFFF * 0xFFFFFFFF -> 0x00000000. MULHU, same operands -> 0xFFFFFFFE. MUL, 7*6 -> 42 at latency 1.
- Divide: DIV, -7/2 -> 0xFFFFFFFD with out_valid at cycle 33 and busy=1 for cycles 1-32. REM, -7/2 -> 0xFFFFFFFF. DIVU, x/0 -> 0xFFFFFFFF. REM, 9/0 -> 9. DIV, 0x80000000/-1 -> 0x80000000 and REM -> 0.
- Backpressure: out_ready=0 with a result held for 5 cycles -> result and tag stable, in_ready=0. Release -> the queued op is accepted the same cycle.
- Flush/reset mid-op: DIVU started, flush at cycle 10 -> busy=0 and out_valid never rises for that op, next op accepted normally. Repeat with rst at cycle 10 -> reset values.

Source files
------------

// File: rtl/ex_alu_unit_if.sv
// Execute-stage ALU bus: operand/op request side, result side, flush and busy.
interface ex_alu_unit_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [XLEN-1:0]  pc_ex;
  logic [XLEN-1:0]  reg_1_in;
  logic [XLEN-1:0]  reg_2_in;
  logic [XLEN-1:0]  imm_data_in;
  logic [1:0]       alu_mode_select;
  logic [4:0]       alu_op;
  logic [TAG_W-1:0] tag_in;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  alu_result_out;
  logic             alu_zero_out;
  logic [TAG_W-1:0] tag_out;
  logic             busy;

  modport master (
    output flush, in_valid, pc_ex, reg_1_in, reg_2_in, imm_data_in,
           alu_mode_select, alu_op, tag_in, out_ready,
    input  in_ready, out_valid, alu_result_out, alu_zero_out, tag_out, busy
  );

  modport slave (
    input  flush, in_valid, pc_ex, reg_1_in, reg_2_in, imm_data_in,
           alu_mode_select, alu_op, tag_in, out_ready,
    output in_ready, out_valid, alu_result_out, alu_zero_out, tag_out, busy
  );
endinterface

// File: rtl/ex_alu_unit.sv
// Execute-stage ALU: operand select, RV32I ops, RV32M multiply and an
// iterative restoring divider behind a valid/ready handshake.
//
// state   | meaning
// --------+---------------------------------------------------------
// S_IDLE  | accepting ops; single-cycle results load the output reg
// S_DIV   | divider iterating, one quotient bit per cycle, busy=1
module ex_alu_unit #(
  parameter int XLEN    = 32,
  parameter int TAG_W   = 5,
  parameter int PC_STEP = 4
) (
  input logic          clk,
  input logic          rst,
  ex_alu_unit_if.slave bus
);
  localparam int SH_W  = $clog2(XLEN);
  localparam int CNT_W = SH_W + 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(XLEN);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_DIV  = 1'b1;

  logic [0:0]       state;
  logic             out_valid_q;
  logic [XLEN-1:0]  result_q;
  logic             zero_q;
  logic [TAG_W-1:0] tag_q;

  logic [XLEN-1:0]  quo_q, rem_q, dvs_q;
  logic [CNT_W-1:0] cnt_q;
  logic             is_rem_q, q_neg_q, r_neg_q, b_zero_q;
  logic [TAG_W-1:0] div_tag_q;

  logic             in_ready, accept, is_div, div_signed;
  logic             a_sx, b_sx, a_neg, b_neg;
  logic [XLEN-1:0]  op_a, op_b, alu_res, a_mag, b_mag;
  logic [SH_W-1:0]  shamt;
  logic [2*XLEN-1:0] mul_a, mul_b, prod;
  logic [XLEN:0]    rem_shift, rem_diff;
  logic [XLEN-1:0]  quo_nxt, rem_nxt, div_res;

  assign in_ready = (state == S_IDLE) && (!out_valid_q || bus.out_ready) && !rst && !bus.flush;
  assign accept   = bus.in_valid && in_ready;
  assign is_div   = (bus.alu_op[4:2] == 3'b101);
  assign div_signed = !bus.alu_op[0];

  // Operand selection: A is rs1 or pc, B is rs2, imm or the link step
  always_comb begin
    op_a = bus.alu_mode_select[1] ? bus.pc_ex : bus.reg_1_in;
    case (bus.alu_mode_select)
      2'd0:    op_b = bus.reg_2_in;
      2'd1:    op_b = bus.imm_data_in;
      2'd2:    op_b = bus.imm_data_in;
      default: op_b = XLEN'(PC_STEP);
    endcase
  end

  // Full-width product; sign-extending to 2*XLEN makes one multiplier serve all variants
  always_comb begin
    a_sx  = (bus.alu_op == 5'd17) || (bus.alu_op == 5'd18);
    b_sx  = (bus.alu_op == 5'd17);
    mul_a = {{XLEN{a_sx & op_a[XLEN-1]}}, op_a};
    mul_b = {{XLEN{b_sx & op_b[XLEN-1]}}, op_b};
    prod  = mul_a * mul_b;
  end

  // Single-cycle result
  always_comb begin
    shamt   = op_b[SH_W-1:0];
    alu_res = '0;
    case (bus.alu_op)
      5'd0:  alu_res = op_a + op_b;
      5'd1:  alu_res = op_a - op_b;
      5'd2:  alu_res = op_a << shamt;
      5'd3:  alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      5'd4:  alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
      5'd5:  alu_res = op_a ^ op_b;
      5'd6:  alu_res = op_a >> shamt;
      5'd7:  alu_res = XLEN'($signed(op_a) >>> shamt);
      5'd8:  alu_res = op_a | op_b;
      5'd9:  alu_res = op_a & op_b;
      5'd10: alu_res = op_b;
      5'd16: alu_res = prod[XLEN-1:0];
      5'd17, 5'd18, 5'd19: alu_res = prod[2*XLEN-1:XLEN];
      default: alu_res = '0;
    endcase
  end

  // Divider operand prep on magnitudes, one restoring step, final sign fix-up
  always_comb begin
    a_neg     = div_signed & op_a[XLEN-1];
    b_neg     = div_signed & op_b[XLEN-1];
    a_mag     = a_neg ? -op_a : op_a;
    b_mag     = b_neg ? -op_b : op_b;
    rem_shift = {rem_q, quo_q[XLEN-1]};
    rem_diff  = rem_shift - {1'b0, dvs_q};
    if (!rem_diff[XLEN]) begin
      rem_nxt = rem_diff[XLEN-1:0];
      quo_nxt = {quo_q[XLEN-2:0], 1'b1};
    end else begin
      rem_nxt = rem_shift[XLEN-1:0];
      quo_nxt = {quo_q[XLEN-2:0], 1'b0};
    end
    // Divide-by-zero quotient is all ones regardless of dividend sign
    if (is_rem_q)      div_res = r_neg_q ? -rem_nxt : rem_nxt;
    else if (b_zero_q) div_res = '1;
    else               div_res = q_neg_q ? -quo_nxt : quo_nxt;
  end

  // Control FSM and output register
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b1;
      tag_q       <= '0;
    end else if (bus.flush) begin
      state       <= S_IDLE;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (is_div) begin
              state       <= S_DIV;
              out_valid_q <= 1'b0;
            end else begin
              out_valid_q <= 1'b1;
              result_q    <= alu_res;
              zero_q      <= (alu_res == '0);
              tag_q       <= bus.tag_in;
            end
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          if (cnt_q == CNT_ONE) begin
            state       <= S_IDLE;
            out_valid_q <= 1'b1;
            result_q    <= div_res;
            zero_q      <= (div_res == '0);
            tag_q       <= div_tag_q;
          end
        end
      endcase
    end
  end

  // Divider datapath: load on accept, iterate while running
  always_ff @(posedge clk) begin
    if (state == S_IDLE) begin
      if (accept && is_div) begin
        quo_q     <= a_mag;
        rem_q     <= '0;
        dvs_q     <= b_mag;
        cnt_q     <= CNT_INIT;
        is_rem_q  <= bus.alu_op[1];
        q_neg_q   <= a_neg ^ b_neg;
        r_neg_q   <= a_neg;
        b_zero_q  <= (op_b == '0);
        div_tag_q <= bus.tag_in;
      end
    end else begin
      quo_q <= quo_nxt;
      rem_q <= rem_nxt;
      cnt_q <= cnt_q - CNT_ONE;
    end
  end

  assign bus.in_ready       = in_ready;
  assign bus.out_valid      = out_valid_q;
  assign bus.alu_result_out = result_q;
  assign bus.alu_zero_out   = zero_q;
  assign bus.tag_out        = tag_q;
  assign bus.busy           = (state == S_DIV);
endmodule
